// File: rtl/div_iter_pkg.sv
// -----------------------------------------------------------------------------
// div_iter_pkg
// Shared CPU package for the iterative divider.
//   div_state_t : IDLE / BUSY / DONE controller states
//   DIV_WIDTH   : default operand/result width
//   cnt_width() : bits needed to hold an iteration count of 0..w
//   CNT_W       : counter width for the default width
// -----------------------------------------------------------------------------
package div_iter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH = 32;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/div_sign_fix.sv
// -----------------------------------------------------------------------------
// div_sign_fix
// Combinational conditional two's-complement negate. Used to take operand
// magnitudes (negate when the sign-extended operand is negative) and to apply
// the final sign to quotient and remainder.
//   W      : data width
//   value  : input word
//   negate : 1 = output is -value, 0 = output is value
//   result : conditionally negated word
// -----------------------------------------------------------------------------
module div_sign_fix #(
    parameter int W = 33
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    assign result = negate ? (~value + {{(W-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/div_iter.sv
// -----------------------------------------------------------------------------
// div_iter
// Iterative radix-2 restoring divider for MIPS DIV/DIVU in the execute stage.
// One quotient bit per cycle; quotient goes to LO, remainder to HI.
//   clk          : pipeline clock
//   rst          : synchronous active-high reset
//   start        : E stage holds a DIV/DIVU (level, held while E is stalled)
//   is_signed    : 1 = DIV, 0 = DIVU (sampled with start)
//   dividend     : rs value (sampled with start)
//   divisor      : rt value (sampled with start)
//   cancel       : M-stage exception flush, aborts any operation
//   div_stall    : E-stage divide stall towards the hazard unit
//   result_valid : one-cycle completion pulse
//   quotient     : LO result, held until the next completion
//   remainder    : HI result, held until the next completion
// Optional feature macro: DIV_EARLY_OUT_EN -- when defined, an operation whose
// dividend magnitude is below a non-zero divisor magnitude finishes in one
// stall cycle (quotient 0, remainder = dividend).
// -----------------------------------------------------------------------------
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    output logic             div_stall,
    output logic             result_valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = cnt_width(WIDTH);

    div_state_t       state_reg, state_next;
    logic [WIDTH:0]   rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH:0]   dsr_reg;
    logic [CW-1:0]    cnt_reg;
    logic             q_sign_reg, r_sign_reg;
    logic [WIDTH-1:0] q_hold_reg, r_hold_reg;

    logic             accept, step, early;

    // Operand magnitudes, one bit wider so |most-negative| is representable.
    logic [WIDTH:0] dvd_ext, dsr_ext, dvd_mag, dsr_mag;
    assign dvd_ext = {is_signed & dividend[WIDTH-1], dividend};
    assign dsr_ext = {is_signed & divisor[WIDTH-1], divisor};

    div_sign_fix #(.W(WIDTH + 1)) u_abs_dividend (
        .value  (dvd_ext),
        .negate (dvd_ext[WIDTH]),
        .result (dvd_mag)
    );

    div_sign_fix #(.W(WIDTH + 1)) u_abs_divisor (
        .value  (dsr_ext),
        .negate (dsr_ext[WIDTH]),
        .result (dsr_mag)
    );

`ifdef DIV_EARLY_OUT_EN
    assign early = (dvd_mag < dsr_mag) && (divisor != '0);
`else
    assign early = 1'b0;
`endif

    // One restoring step: shift in the next dividend bit, trial-subtract.
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             sub_ok;
    assign shifted = {rem_reg[WIDTH-1:0], quo_reg[WIDTH-1]};
    assign diff    = {1'b0, shifted} - {1'b0, dsr_reg};
    assign sub_ok  = ~diff[WIDTH+1];

    // Result sign fixup; the quotient is extended so that an all-ones
    // magnitude (divide by zero) negates as a magnitude, not as -1.
    logic [WIDTH:0] q_fix, r_fix;

    div_sign_fix #(.W(WIDTH + 1)) u_fix_quotient (
        .value  ({1'b0, quo_reg}),
        .negate (q_sign_reg),
        .result (q_fix)
    );

    div_sign_fix #(.W(WIDTH + 1)) u_fix_remainder (
        .value  (rem_reg),
        .negate (r_sign_reg),
        .result (r_fix)
    );

    // Bits that never matter: results wrap to WIDTH, and the top magnitude
    // bit only feeds the comparisons above.
    logic unused_bits;
    assign unused_bits = ^{q_fix[WIDTH], r_fix[WIDTH], dvd_mag[WIDTH], diff[WIDTH]};

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        accept       = 1'b0;
        step         = 1'b0;
        result_valid = 1'b0;
        if (cancel) begin
            state_next = IDLE;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (start) begin
                        accept     = 1'b1;
                        state_next = early ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    step = 1'b1;
                    if (cnt_reg == CW'(1)) begin
                        state_next = DONE;
                    end
                end
                DONE: begin
                    // start is still high for the same instruction; ignore it.
                    result_valid = 1'b1;
                    state_next   = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign div_stall = (((state_reg == IDLE) && start) || (state_reg == BUSY)) && !cancel;

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_reg    <= '0;
            quo_reg    <= '0;
            dsr_reg    <= '0;
            cnt_reg    <= '0;
            q_sign_reg <= 1'b0;
            r_sign_reg <= 1'b0;
            q_hold_reg <= '0;
            r_hold_reg <= '0;
        end else begin
            if (accept) begin
                // Early out parks the dividend magnitude as the remainder
                // with a zero quotient; the shared fixup restores its sign.
                rem_reg    <= early ? dvd_mag : '0;
                quo_reg    <= early ? '0 : dvd_mag[WIDTH-1:0];
                dsr_reg    <= dsr_mag;
                cnt_reg    <= CW'(WIDTH);
                q_sign_reg <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                r_sign_reg <= is_signed & dividend[WIDTH-1];
            end else if (step) begin
                rem_reg <= sub_ok ? diff[WIDTH:0] : shifted;
                quo_reg <= {quo_reg[WIDTH-2:0], sub_ok};
                cnt_reg <= cnt_reg - CW'(1);
            end
            if (result_valid) begin
                q_hold_reg <= q_fix[WIDTH-1:0];
                r_hold_reg <= r_fix[WIDTH-1:0];
            end
        end
    end

    assign quotient  = result_valid ? q_fix[WIDTH-1:0] : q_hold_reg;
    assign remainder = result_valid ? r_fix[WIDTH-1:0] : r_hold_reg;

endmodule

// File: tb/tb_div_iter.sv
// -----------------------------------------------------------------------------
// tb_div_iter
// Directed scoreboard bench for div_iter. The stimulus process pushes the
// hand-computed quotient, remainder and stall length of each divide; a
// separate monitor pops and compares on every result_valid pulse.
// -----------------------------------------------------------------------------
module tb_div_iter;

`ifdef DIV_EARLY_OUT_EN
    localparam int EO_STALL = 1;
`else
    localparam int EO_STALL = 33;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        cancel;
    logic        div_stall;
    logic        result_valid;
    logic [31:0] quotient;
    logic [31:0] remainder;

    always #5 clk = ~clk;

    div_iter #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .is_signed    (is_signed),
        .dividend     (dividend),
        .divisor      (divisor),
        .cancel       (cancel),
        .div_stall    (div_stall),
        .result_valid (result_valid),
        .quotient     (quotient),
        .remainder    (remainder)
    );

    typedef struct {
        string       name;
        logic [31:0] q;
        logic [31:0] r;
        int          stall;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, req);
        end
    endtask

    // ------------------------------------------------------------ monitor
    initial begin : monitor
        int   stall_cnt;
        exp_t e;
        stall_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst || cancel) begin
                stall_cnt = 0;
            end else begin
                if (div_stall) stall_cnt++;
                if (result_valid) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_result actual=q 0x%08h r 0x%08h required=no result_valid",
                                 quotient, remainder);
                    end else begin
                        e = sb.pop_front();
                        $display("txn %s: q=0x%08h r=0x%08h stall=%0d", e.name, quotient, remainder, stall_cnt);
                        chk({e.name, "_q"}, quotient, e.q);
                        chk({e.name, "_r"}, remainder, e.r);
                        chk({e.name, "_stall"}, 32'(stall_cnt), 32'(e.stall));
                    end
                    stall_cnt = 0;
                end
            end
        end
    end

    // ----------------------------------------------------------- stimulus
    task automatic do_div(input string nm, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] q,
                          input logic [31:0] r, input int stall);
        exp_t e;
        bit   got;
        e.name = nm; e.q = q; e.r = r; e.stall = stall;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b1; is_signed = sg; dividend = a; divisor = b;
        got = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (result_valid) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no result_valid required=result within 100 cycles", nm);
            sb.delete();
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin : stim
        rst = 1'b1; start = 1'b0; is_signed = 1'b0;
        dividend = '0; divisor = '0; cancel = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_stall", 32'(div_stall), 32'd0);
        chk("reset_valid", 32'(result_valid), 32'd0);
        chk("reset_q", quotient, 32'd0);
        chk("reset_r", remainder, 32'd0);

        do_div("divu_100_7",  1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33);
        do_div("div_m7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33);
        do_div("div_7_m2",    1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33);
        do_div("div_m7_m2",   1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  33);
        do_div("div_min_m1",  1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33);
        do_div("divu_5_0",    1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          33);
        do_div("div_m8_0",    1'b1, 32'hFFFF_FFF8,  32'd0,          32'd1,          32'hFFFF_FFF8,  33);
        do_div("divu_max_16", 1'b0, 32'hFFFF_FFFF,  32'd16,         32'h0FFF_FFFF,  32'd15,         33);

        // Cancel in cycle 10 of a 100/7, then 9/3 starting in cycle 12.
        @(posedge clk); #1;
        start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
        repeat (10) @(posedge clk);
        #1 cancel = 1'b1;
        @(negedge clk);
        chk("cancel_stall", 32'(div_stall), 32'd0);
        chk("cancel_valid", 32'(result_valid), 32'd0);
        @(posedge clk); #1;
        cancel = 1'b0; start = 1'b0;
        do_div("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);
        @(negedge clk);
        chk("hold_q", quotient, 32'd3);

        do_div("divu_3_10", 1'b0, 32'd3,         32'd10, 32'd0, 32'd3,         EO_STALL);
        do_div("div_m3_10", 1'b1, 32'hFFFF_FFFD, 32'd10, 32'd0, 32'hFFFF_FFFD, EO_STALL);

        // Reset in the middle of an operation: no result, unit idle.
        @(posedge clk); #1;
        start = 1'b1; is_signed = 1'b0; dividend = 32'd50; divisor = 32'd3;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1; start = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_valid", 32'(result_valid), 32'd0);
            chk("midrst_stall", 32'(div_stall), 32'd0);
        end
        chk("midrst_q", quotient, 32'd0);

        do_div("divu_after_rst", 1'b0, 32'd50, 32'd3, 32'd16, 32'd2, 33);
        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL pending_results actual=%0d required=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_iter.md
# div_iter

Iterative 32-bit MIPS DIV/DIVU unit in the execute stage. Accepts one divide per instruction and runs a radix-2 restoring loop, one quotient bit per cycle. It drives the execute-stage divide-stall signal that the hazard unit ORs into the pipeline-wide stall. It returns quotient (LO) and remainder (HI) for one cycle when the operation completes.

## Interface
- WIDTH, 32, operand/result width
- clk  input  1  pipeline clock
- rst  input  1  synchronous, active-high reset
- start  input  1  E-stage holds a valid DIV/DIVU; level, stays high while E is held
- is_signed  input  1  1 = DIV, 0 = DIVU; sampled with start
- dividend  input  WIDTH  rs value; sampled with start
- divisor  input  WIDTH  rt value; sampled with start
- cancel  input  1  flush from M-stage exception; aborts any operation
- div_stall  output  1  to hazard unit as E_div_stall
- result_valid  output  1  one-cycle completion pulse
- quotient  output  WIDTH  LO result, valid when result_valid
- remainder  output  WIDTH  HI result, valid when result_valid

## Operation
- States: IDLE, BUSY, DONE. Reset puts the unit in IDLE with all internal registers cleared.
- Reset output values: div_stall=0, result_valid=0, quotient=0, remainder=0.
- IDLE with start=1 and cancel=0:
  - latch |dividend|, |divisor|, quotient sign (signed & sign differs), remainder sign (signed & dividend negative)
  - clear the partial remainder, load counter = WIDTH, go to BUSY
- BUSY, each cycle:
  - shift {rem, quo} left by 1 and trial-subtract the divisor magnitude
  - if no borrow, keep the difference and set quo bit 0 = 1
  - decrement the counter; at 1, go to DONE
- DONE:
  - result_valid=1; outputs carry the sign-fixed results
  - start is ignored here, because the same instruction is still presented
  - go to IDLE unconditionally
- Outputs hold the last result after DONE until the next completion.
- Sign fix:
  - quotient is negated if the quotient sign is set
  - remainder is negated if the remainder sign is set (remainder follows the dividend's sign)
- Arithmetic rules:
  - all magnitudes use WIDTH+1 bits internally so that |0x80000000| is representable
  - 0x80000000 / 0xFFFFFFFF signed gives quotient 0x80000000, remainder 0 (wrap)
- Divide by zero gets no special handling. The unit runs the normal loop: quotient magnitude all ones, remainder magnitude = |dividend|, then sign fix.
- div_stall = ((IDLE & start) | BUSY) & ~cancel. This is combinational, so E is held in the same cycle that start is first seen.
- cancel has priority in every state:
  - next state is IDLE, and result_valid is suppressed in that cycle
  - start in the same cycle is not accepted
- rst mid-operation: IDLE next cycle, with no result pulse.

## Timing
- Cycle 0: start seen, div_stall=1.
- Cycles 1..WIDTH: BUSY, div_stall=1.
- Cycle WIDTH+1: DONE, div_stall=0, result_valid=1; the E instruction advances.
- Total stall is WIDTH+1 cycles (33). A back-to-back divide can start in the cycle after DONE.
- cancel at any cycle drops div_stall in that same cycle.

## Configuration
- DIV_EARLY_OUT_EN defined:
  - in cycle 0, if |dividend| < |divisor| (unsigned magnitude compare, divisor ≠ 0), skip BUSY and go straight to DONE
  - results: quotient=0, remainder=dividend
  - total stall is 1 cycle
- Undefined: every operation takes the full WIDTH+1-cycle latency.

## Structure
- Shared CPU package holds:
  - the state enum (IDLE/BUSY/DONE)
  - the WIDTH default
  - the counter width constant, $clog2(WIDTH+1)
- One sub-module, div_sign_fix: combinational magnitude/negate helper, instantiated for operand abs and for result fixup.

## Test plan
- DIVU 100 / 7 → div_stall high for exactly 33 cycles; result_valid in cycle 33 with quotient=14, remainder=2.
- DIV 0xFFFFFFF9 (−7) / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0, no hang.
- DIVU 5 / 0 → quotient 0xFFFFFFFF, remainder 5 after 33 cycles.
- Start 100/7, assert cancel in cycle 10:
  - div_stall=0 in cycle 10
  - no result_valid
  - new start 9/3 in cycle 12 gives quotient 3, remainder 0
- With DIV_EARLY_OUT_EN, DIVU 3 / 10 → div_stall high in cycle 0 only; cycle 1 result_valid, quotient 0, remainder 3. Without the macro: same values in cycle 33.
